// File: rtl/pc_ctrl.sv
// Program-counter controller: sequential step, absolute/relative branch, call/return via a circular return-address stack.
// Build option: define PC_CTRL_RAS_EN to compile in the return-address stack; otherwise calls act as branches and returns are ignored.
module pc_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int RESET_VEC = 0,
  parameter int STEP      = 1,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_en,
  input  logic              br_rel,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              call_en,
  input  logic              ret_en,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_next,
  output logic              ras_full,
  output logic              ras_empty,
  output logic              ras_err
);

  localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] tgt_pc;

  // Offset and address share one width, so the relative add wraps naturally.
  assign seq_pc = pc_q + STEP_V;
  assign tgt_pc = br_rel ? (pc_q + br_target) : br_target;

`ifdef PC_CTRL_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  top_q;
  logic [PTR_W-1:0]  top_d;
  logic [PTR_W-1:0]  top_m1;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              err_q;
  logic              err_d;
  logic              push;

  // top_q is the next write slot; when full it also addresses the oldest entry.
  assign top_m1 = top_q - PTR_W'(1);

  always_comb begin
    pc_d  = seq_pc;
    top_d = top_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    push  = 1'b0;
    if (stall) begin
      pc_d = pc_q;
    end else if (ret_en) begin
      if (cnt_q != '0) begin
        pc_d  = ras_mem_q[top_m1];
        top_d = top_m1;
        cnt_d = cnt_q - CNT_W'(1);
        err_d = call_en;
      end else begin
        err_d = 1'b1;
      end
    end else if (call_en) begin
      push  = 1'b1;
      pc_d  = tgt_pc;
      top_d = top_q + PTR_W'(1);
      if (cnt_q == CNT_FULL) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (br_en) begin
      pc_d = tgt_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras_entry
    always_ff @(posedge clk) begin
      if (!reset && push && (top_q == PTR_W'(gi))) begin
        ras_mem_q[gi] <= seq_pc;
      end
    end
  end

  assign ras_full  = (cnt_q == CNT_FULL);
  assign ras_empty = (cnt_q == '0);
  assign ras_err   = err_q;
`else
  logic unused_ret;
  assign unused_ret = ret_en;

  always_comb begin
    pc_d = seq_pc;
    if (stall) begin
      pc_d = pc_q;
    end else if (call_en || br_en) begin
      pc_d = tgt_pc;
    end
  end

  assign ras_full  = 1'b0;
  assign ras_empty = 1'b1;
  assign ras_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_V;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_out  = pc_q;
  assign pc_next = reset ? RESET_V : pc_d;

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, sets the program-address width in bits.
REQ-002 Parameter RESET_VEC, default 0, is the address loaded on reset.
REQ-003 Parameter STEP, default 1, is the sequential increment.
REQ-004 Parameter RAS_DEPTH, default 4, sets the return-address-stack entry count (power of two, at least 2).
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 reset  in  1  reset; synchronous, active-high.
REQ-007 stall  in  1  hold all state this cycle.
REQ-008 br_en  in  1  branch request this cycle.
REQ-009 br_rel  in  1  1 = br_target is a signed offset from pc_out; 0 = absolute address.
REQ-010 br_target  in  ADDR_W  branch/call target address or offset.
REQ-011 call_en  in  1  call request: push the return address and load the target.
REQ-012 ret_en  in  1  return request: pop into the PC.
REQ-013 pc_out  out  ADDR_W  registered current PC.
REQ-014 pc_next  out  ADDR_W  combinational value pc_out takes at the next edge.
REQ-015 ras_full  out  1  stack holds RAS_DEPTH entries.
REQ-016 ras_empty  out  1  stack holds 0 entries.
REQ-017 ras_err  out  1  one-cycle pulse on overflow, underflow or a call/ret conflict.

Function
REQ-018 Priority is reset > stall > ret_en > call_en > br_en > sequential increment.
REQ-019 Sequential increment: pc_next = pc_out + STEP, modulo 2^ADDR_W, so PC wraps silently.
REQ-020 Target resolution (branch and call): br_rel=1 gives pc_out + sign-extended br_target, modulo 2^ADDR_W; br_rel=0 gives br_target.
REQ-021 br_en alone loads the resolved target with one-cycle latency (visible on pc_out the cycle after the request).
REQ-022 call_en:
  - pushes pc_out + STEP onto the stack;
  - loads the resolved target;
  - br_en is ignored in the same cycle.
REQ-023 ret_en with a non-empty stack loads the top entry and pops it.
REQ-024 ret_en with an empty stack increments the PC sequentially, leaves the stack unchanged and pulses ras_err.
REQ-025 Call on a full stack:
  - overwrites the oldest entry (circular buffer);
  - count stays at RAS_DEPTH;
  - pulses ras_err.
REQ-026 ret_en and call_en together: the return executes, the call is dropped, and ras_err pulses.
REQ-027 stall=1 holds pc_out, the stack contents and the count, ignores every request, and forces ras_err=0.
REQ-028 pc_next reflects the stall, priority and stack state so it is always equal to the next pc_out.
REQ-029 ras_full and ras_empty are decoded from a registered count of width clog2(RAS_DEPTH)+1.

Reset
REQ-030 While reset=1 at a rising edge:
  - pc_out becomes RESET_VEC;
  - the stack count becomes 0 (ras_empty=1, ras_full=0);
  - ras_err becomes 0.
REQ-031 Reset overrides stall and all requests, including an operation in progress.
REQ-032 Stack entry contents are don't-care after reset.
REQ-033 The first post-reset edge with reset=0 applies normal priority.

Configuration
REQ-034 Macro PC_CTRL_RAS_EN defined: the return-address stack and all behaviour in REQ-022 to REQ-026 are compiled in.
REQ-035 Macro PC_CTRL_RAS_EN undefined, the stack is removed and the following apply:
  - call_en behaves as br_en (no push);
  - ret_en is ignored and the PC increments;
  - ras_full=0, ras_empty=1 and ras_err=0 constantly.

Verification
REQ-036 Reset test: RESET_VEC=0x0100, reset held 2 cycles then released with no requests -> pc_out = 0x0100, 0x0101, 0x0102 on successive cycles.
REQ-037 Relative branch test: pc_out=0x0010, br_en=1, br_rel=1, br_target=0xFFFC -> pc_out=0x000C next cycle. Then br_rel=0, br_target=0x1234 -> pc_out=0x1234.
REQ-038 Stack fill and drain (RAS_DEPTH=4):
  - call from 0x0000, 0x0010, 0x0020, 0x0030 -> ras_full=1.
  - A fifth call from 0x0040 -> ras_err pulses.
  - Four returns -> pc_out = 0x0041, 0x0031, 0x0021, 0x0011, then ras_empty=1.
REQ-039 Underflow and conflict:
  - ret_en on an empty stack at pc_out=0x0050 -> pc_out=0x0051, ras_err=1 for one cycle.
  - call_en and ret_en together -> the return executes and ras_err pulses.
REQ-040 Stall and reset: stall=1 for 3 cycles with br_en=1 -> pc_out and count unchanged. reset=1 during stall -> pc_out=RESET_VEC next edge. PC at 0xFFFF with no request -> wraps to 0x0000.
